// File: rtl/unidade_controle_jogada.sv
// Turn controller for the macro/micro board game: button capture, move validation, write and turn handover.
// Optional build macro UCJ_TIMEOUT_EN adds a per-turn timeout that passes the turn to the other player.
module unidade_controle_jogada #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [8:0] botoes,
  input  logic       macro_livre,
  input  logic       micro_livre,
  input  logic       fim_jogo,
  output logic [3:0] macro_sel,
  output logic [3:0] micro_sel,
  output logic       limpa,
  output logic       escreve,
  output logic       jogador,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       pronto,
  output logic [3:0] db_estado,
  output logic       db_timeout
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    ESPERA_MACRO = 4'd2,
    VALIDA_MACRO = 4'd3,
    ESPERA_MICRO = 4'd4,
    VALIDA_MICRO = 4'd5,
    ESCREVE      = 4'd6,
    VERIFICA     = 4'd7,
    TROCA        = 4'd8,
    CHECA_PROX   = 4'd9,
    FIM          = 4'd15
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] macro_sel_q, macro_sel_d;
  logic [3:0] micro_sel_q, micro_sel_d;
  logic       jogador_q, jogador_d;
  logic [8:0] bot_s1_q, bot_s2_q, bot_hist_q;
  logic       onehot, press_ok, tmo;
  logic [3:0] press_idx;

  // Buttons are asynchronous: two-flop synchronizer, then a history stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bot_s1_q   <= '0;
      bot_s2_q   <= '0;
      bot_hist_q <= '0;
    end else begin
      bot_s1_q   <= botoes;
      bot_s2_q   <= bot_s1_q;
      bot_hist_q <= bot_s2_q;
    end
  end

  assign onehot   = (bot_s2_q != '0) && ((bot_s2_q & (bot_s2_q - 9'd1)) == '0);
  assign press_ok = onehot && (bot_hist_q == '0);

  always_comb begin
    press_idx = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (bot_s2_q[k]) press_idx = 4'(k);
    end
  end

`ifdef UCJ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             esperando;

  assign esperando = (estado_q == ESPERA_MACRO) || (estado_q == ESPERA_MICRO);
  assign tmo       = esperando && !press_ok && (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
  // Any cycle outside the waiting states leaves the counter at zero, so entry starts a fresh turn.
  assign cnt_d     = (esperando && !press_ok && !tmo) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      macro_sel_q <= 4'd0;
      micro_sel_q <= 4'd0;
      jogador_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      macro_sel_q <= macro_sel_d;
      micro_sel_q <= micro_sel_d;
      jogador_q   <= jogador_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    macro_sel_d = macro_sel_q;
    micro_sel_d = micro_sel_q;
    jogador_d   = jogador_q;
    unique case (estado_q)
      INICIAL:      if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        jogador_d = 1'b0;
        estado_d  = ESPERA_MACRO;
      end
      ESPERA_MACRO: begin
        if (press_ok) begin
          macro_sel_d = press_idx;
          estado_d    = VALIDA_MACRO;
        end else if (tmo) begin
          jogador_d = ~jogador_q;
        end
      end
      VALIDA_MACRO: estado_d = macro_livre ? ESPERA_MICRO : ESPERA_MACRO;
      ESPERA_MICRO: begin
        if (press_ok) begin
          micro_sel_d = press_idx;
          estado_d    = VALIDA_MICRO;
        end else if (tmo) begin
          jogador_d = ~jogador_q;
        end
      end
      VALIDA_MICRO: estado_d = micro_livre ? ESCREVE : ESPERA_MICRO;
      ESCREVE:      estado_d = VERIFICA;
      VERIFICA:     estado_d = fim_jogo ? FIM : TROCA;
      TROCA: begin
        // The cell just played names the macro the opponent is sent to.
        jogador_d   = ~jogador_q;
        macro_sel_d = micro_sel_q;
        estado_d    = CHECA_PROX;
      end
      CHECA_PROX:   estado_d = macro_livre ? ESPERA_MICRO : ESPERA_MACRO;
      FIM:          if (iniciar) estado_d = PREPARA;
      default:      estado_d = INICIAL;
    endcase
  end

  assign macro_sel   = macro_sel_q;
  assign micro_sel   = micro_sel_q;
  assign jogador     = jogador_q;
  assign limpa       = (estado_q == PREPARA);
  assign escreve     = (estado_q == ESCREVE);
  assign jogar_macro = (estado_q == ESPERA_MACRO);
  assign jogar_micro = (estado_q == ESPERA_MICRO);
  assign pronto      = (estado_q == FIM);
  assign db_estado   = estado_q;
  assign db_timeout  = tmo;

endmodule

// File: doc/unidade_controle_jogada.md
UNIDADE_CONTROLE_JOGADA -- requirements
Module: unidade_controle_jogada

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 5000, gives the turn timeout length in clock cycles; it is used only with UCJ_TIMEOUT_EN.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 iniciar  in  1  starts a new game from inicial or fim.
REQ-005 botoes  in  9  player buttons; bit k selects cell/macro index k (0..8).
REQ-006 macro_livre  in  1  datapath: the macro at macro_sel is not closed (won or full).
REQ-007 micro_livre  in  1  datapath: the cell macro_sel/micro_sel is empty.
REQ-008 fim_jogo  in  1  datapath: the game is won or drawn after the last write.
REQ-009 macro_sel, micro_sel  out  4  registered selected macro and cell index.
REQ-010 limpa, escreve  out  1  one-cycle pulses that clear the board and write the jogador mark.
REQ-011 jogador  out  1  current player (0 = J1, 1 = J2).
REQ-012 jogar_macro, jogar_micro, pronto  out  1  awaiting a macro, awaiting a cell, game over.
REQ-013 db_estado  out  4  current state code; db_timeout  out  1  one-cycle pulse when a turn times out.

Function
REQ-014 States and db_estado codes: inicial=0, prepara=1, espera_macro=2, valida_macro=3, espera_micro=4, valida_micro=5, escreve=6, verifica=7, troca=8, checa_prox=9, fim=15.
REQ-015 A press is valid only when botoes is one-hot and botoes was all-zero in the previous cycle; any multi-bit pattern or a held button is ignored.
REQ-016 inicial: the block moves to prepara when iniciar=1.
REQ-017 prepara: the block asserts limpa for one cycle, sets jogador=0, then moves to espera_macro.
REQ-018 espera_macro: jogar_macro=1; on a valid press the block loads macro_sel=k and moves to valida_macro on the next edge.
REQ-019 valida_macro: if macro_livre=1 the block moves to espera_micro; otherwise it returns to espera_macro with no player change.
REQ-020 espera_micro: jogar_micro=1; on a valid press the block loads micro_sel=k and moves to valida_micro.
REQ-021 valida_micro: if micro_livre=1 the block moves to escreve; otherwise it returns to espera_micro.
REQ-022 escreve: the block asserts escreve for exactly one cycle, then moves to verifica.
REQ-023 verifica: if fim_jogo=1 the block moves to fim; otherwise it moves to troca.
REQ-024 troca: jogador toggles, macro_sel<=micro_sel, and the block moves to checa_prox.
REQ-025 checa_prox: if macro_livre=1 the block moves to espera_micro (forced macro); otherwise it moves to espera_macro (free choice).
REQ-026 fim: pronto=1 and jogador holds the last mover; iniciar=1 moves the block to prepara.
REQ-027 Latency from a valid press to the escreve pulse is 4 cycles when both validations pass.
REQ-028 jogar_macro, jogar_micro, limpa, escreve and pronto are decoded from the state only and are mutually exclusive.
REQ-029 Buttons pressed in any state other than espera_macro or espera_micro are ignored, and no edge is remembered.

Reset
REQ-030 reset=0 immediately forces inicial, with jogador=0, macro_sel=0, micro_sel=0, all pulses and flags at 0, and db_estado=0, from any state including mid-turn.
REQ-031 After reset is released, iniciar is required to begin play; the edge-detect history register clears to all-zero.

Configuration
REQ-032 With UCJ_TIMEOUT_EN defined:
- a turn counter clears on entry to espera_macro or espera_micro;
- the counter increments each cycle spent in either state and clears on a valid press;
- at count TIMEOUT_CICLOS-1 the block pulses db_timeout, toggles jogador, keeps macro_sel, and re-enters the same waiting state.
REQ-033 Without UCJ_TIMEOUT_EN, no counter is built, db_timeout is constant 0, and the waiting states wait indefinitely.

Verification
REQ-034 reset pulse, then iniciar=1 for 5 cycles -> limpa pulses once, state espera_macro, jogador=0, jogar_macro=1.
REQ-035 botoes=9'b000010000 held 20 cycles with macro_livre=1 -> macro_sel=4, a single acceptance, jogar_micro=1.
REQ-036 botoes=9'b000000001 with micro_livre=1 and macro 0 free -> escreve 4 cycles after the press, jogador=1, macro_sel=0, espera_micro.
REQ-037 macro_livre=0 at checa_prox -> espera_macro; press 4 with macro_livre=0 -> rejected, still espera_macro; press 0 -> accepted.
REQ-038 botoes=9'b000000011 -> ignored; fim_jogo=1 at verifica -> pronto=1, then iniciar -> prepara.
REQ-039 UCJ_TIMEOUT_EN with TIMEOUT_CICLOS=8 and no press -> db_timeout after 8 cycles in espera_macro, jogador toggled.
